systolic_feeder: RTL and testbench

- Upstream stage of the 2-D systolic PE array; produces its `in_data` and `wt_data` buses.
- Accepts activation and weight words over a valid/ready word stream and buffers one full tile: SYS_COL activation lanes and SYS_ROW weight lanes, each K_DEPTH words deep.
- Replays the tile with diagonal skew: lane n is delayed n cycles, so operands meet in the correct PE on the correct cycle.
- Signals tile completion to the controller that later drains results over AXI write.

---
 rtl/systolic_feeder.sv | 130 +++++++++++++
 tb/tb_systolic_feeder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Buffers one activation/weight tile from a valid/ready word stream and replays it
// to the PE array with diagonal skew (lane n delayed n steps), then pulses tile_done.
module systolic_feeder #(
  parameter int SYS_ROW = 9,
  parameter int SYS_COL = 9,
  parameter int K_DEPTH = 9
) (
  input  logic                   M_AXI_ACLK,
  input  logic                   M_AXI_ARESETN,
  input  logic                   init_txn_pulse,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [31:0]            s_data,
  input  logic                   feed_en,
  output logic [SYS_COL*32-1:0]  in_data,
  output logic [SYS_ROW*32-1:0]  wt_data,
  output logic                   feed_valid,
  output logic                   busy,
  output logic                   tile_done
);

  localparam int MAX_RC  = (SYS_ROW > SYS_COL) ? SYS_ROW : SYS_COL;
  localparam int T_STEPS = K_DEPTH + MAX_RC - 1;
  localparam int TW      = $clog2(T_STEPS + 1);
  localparam int LW      = $clog2(MAX_RC + 1);
  localparam int KW      = $clog2(K_DEPTH + 1);
  localparam int KI      = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
  localparam int DW      = TW + 2;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, FEED, DONE} state_t;

  state_t          state_reg, state_next;
  logic [LW-1:0]   ld_lane_reg;
  logic [KW-1:0]   ld_k_reg;
  logic [TW-1:0]   feed_t_reg;
  logic [31:0]     a_mem [SYS_COL][K_DEPTH];
  logic [31:0]     b_mem [SYS_ROW][K_DEPTH];
  logic [SYS_COL*32-1:0] in_next, in_data_reg;
  logic [SYS_ROW*32-1:0] wt_next, wt_data_reg;
  logic            feed_valid_reg;

  logic accept, last_k, last_a, last_b, last_step, issue;

  assign s_ready   = (state_reg == LOAD_A) || (state_reg == LOAD_B);
  assign busy      = s_ready || (state_reg == FEED);
  assign tile_done = (state_reg == DONE);
  assign in_data    = in_data_reg;
  assign wt_data    = wt_data_reg;
  assign feed_valid = feed_valid_reg;

  // A handshake coinciding with a restart is dropped.
  assign accept    = s_valid && s_ready && !init_txn_pulse;
  assign last_k    = (ld_k_reg == KW'(K_DEPTH - 1));
  assign last_a    = last_k && (ld_lane_reg == LW'(SYS_COL - 1));
  assign last_b    = last_k && (ld_lane_reg == LW'(SYS_ROW - 1));
  assign last_step = (feed_t_reg == TW'(T_STEPS - 1));
  // Step 0 can issue on the cycle that accepts the final weight word.
  assign issue = feed_en && !init_txn_pulse &&
                 ((state_reg == FEED) || (state_reg == LOAD_B && accept && last_b));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = IDLE;
      LOAD_A:  if (accept && last_a) state_next = LOAD_B;
      LOAD_B:  if (accept && last_b) state_next = (issue && last_step) ? DONE : FEED;
      FEED:    if (issue && last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (init_txn_pulse) state_next = LOAD_A;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_reg      <= IDLE;
      ld_lane_reg    <= '0;
      ld_k_reg       <= '0;
      feed_t_reg     <= '0;
      feed_valid_reg <= 1'b0;
      in_data_reg    <= '0;
      wt_data_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (init_txn_pulse) begin
        ld_lane_reg <= '0;
        ld_k_reg    <= '0;
        feed_t_reg  <= '0;
      end else begin
        if (accept) begin
          if (last_k) begin
            ld_k_reg    <= '0;
            ld_lane_reg <= ((state_reg == LOAD_A && last_a) || last_b) ? '0 : ld_lane_reg + LW'(1);
          end else begin
            ld_k_reg <= ld_k_reg + KW'(1);
          end
        end
        if (issue) feed_t_reg <= feed_t_reg + TW'(1);
      end
      feed_valid_reg <= issue;
      in_data_reg    <= issue ? in_next : '0;
      wt_data_reg    <= issue ? wt_next : '0;
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (accept && state_reg == LOAD_A) a_mem[ld_lane_reg][ld_k_reg] <= s_data;
    if (accept && state_reg == LOAD_B) b_mem[ld_lane_reg][ld_k_reg] <= s_data;
  end

  // Signed skew index so lanes ahead of the wavefront never alias a valid address.
  genvar gi;
  generate
    for (gi = 0; gi < SYS_COL; gi++) begin : g_act
      logic signed [DW-1:0] a_d;
      logic                 a_ok;
      assign a_d  = $signed({2'b00, feed_t_reg}) - $signed(DW'(gi));
      assign a_ok = (a_d >= 0) && (a_d < $signed(DW'(K_DEPTH)));
      assign in_next[SYS_COL*32-1-32*gi -: 32] = a_ok ? a_mem[gi][a_d[KI-1:0]] : 32'd0;
    end
    for (gi = 0; gi < SYS_ROW; gi++) begin : g_wt
      logic signed [DW-1:0] b_d;
      logic                 b_ok;
      assign b_d  = $signed({2'b00, feed_t_reg}) - $signed(DW'(gi));
      assign b_ok = (b_d >= 0) && (b_d < $signed(DW'(K_DEPTH)));
      assign wt_next[SYS_ROW*32-1-32*gi -: 32] = b_ok ? b_mem[gi][b_d[KI-1:0]] : 32'd0;
    end
  endgenerate

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: reset, clean/gapped loads, feed stalls,
// mid-load restart and mid-feed reset, checked against a closed-form tile model.
module tb_systolic_feeder;

  localparam int R = 9;
  localparam int C = 9;
  localparam int K = 9;
  localparam int T = 17;
  localparam int NW = (R + C) * K;

  logic            clk = 1'b0;
  logic            rstn;
  logic            init_txn_pulse;
  logic            s_valid;
  logic            s_ready;
  logic [31:0]     s_data;
  logic            feed_en;
  logic [C*32-1:0] in_data;
  logic [R*32-1:0] wt_data;
  logic            feed_valid;
  logic            busy;
  logic            tile_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  systolic_feeder #(.SYS_ROW(R), .SYS_COL(C), .K_DEPTH(K)) dut (
    .M_AXI_ACLK     (clk),
    .M_AXI_ARESETN  (rstn),
    .init_txn_pulse (init_txn_pulse),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .feed_en        (feed_en),
    .in_data        (in_data),
    .wt_data        (wt_data),
    .feed_valid     (feed_valid),
    .busy           (busy),
    .tile_done      (tile_done)
  );

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load word n: first the activation tile row-major, then the weight tile.
  function automatic logic [31:0] word(input int n);
    int m;
    if (n < C * K) return 32'(16 * (n / K) + (n % K) + 1);
    m = n - C * K;
    return 32'(256 + 16 * (m / K) + (m % K));
  endfunction

  function automatic logic [287:0] exp_in(input int t);
    logic [287:0] v = '0;
    for (int j = 0; j < C; j++)
      if (t - j >= 0 && t - j < K) v[C*32-1-32*j -: 32] = 32'(16 * j + (t - j) + 1);
    return v;
  endfunction

  function automatic logic [287:0] exp_wt(input int t);
    logic [287:0] v = '0;
    for (int i = 0; i < R; i++)
      if (t - i >= 0 && t - i < K) v[R*32-1-32*i -: 32] = 32'(256 + 16 * i + (t - i));
    return v;
  endfunction

  // Starts a tile; optionally restarts with a junk handshake after abort_after words.
  task automatic load_tile(input int gap_pct, input int abort_after, output int ready_cycles);
    int  n      = 0;
    int  budget = 0;
    bit  aborted = 1'b0;
    ready_cycles = 0;
    init_txn_pulse = 1'b1;
    s_valid = 1'b0;
    tick();
    init_txn_pulse = 1'b0;
    chk("busy_load", 288'(busy), 288'(1));
    while (n < NW && budget < 3000) begin
      budget++;
      if (!aborted && abort_after >= 0 && n == abort_after) begin
        init_txn_pulse = 1'b1;
        s_valid = 1'b1;
        s_data = 32'hBAD0BAD0;
        tick();
        init_txn_pulse = 1'b0;
        aborted = 1'b1;
        n = 0;
        chk("ready_after_abort", 288'(s_ready), 288'(1));
      end else begin
        s_valid = ($urandom_range(0, 99) >= gap_pct);
        s_data = s_valid ? word(n) : 32'h5A5A5A5A;
        if (s_ready) ready_cycles++;
        if (s_ready && s_valid) n++;
        tick();
      end
    end
    s_valid = 1'b0;
    chk("load_words", 288'(n), 288'(NW));
  endtask

  // Entered at the sample point right after the final weight word was accepted.
  task automatic feed_run(input int gap_at, input int gap_len, output int steps,
                          output int dones, output int ready_seen);
    int step = 0;
    steps = 0;
    dones = 0;
    ready_seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (feed_valid) begin
        chk($sformatf("in_step%0d", step), in_data, exp_in(step));
        chk($sformatf("wt_step%0d", step), wt_data, exp_wt(step));
        if (!tile_done) chk("busy_feed", 288'(busy), 288'(1));
        step++;
      end else begin
        chk("in_idle", in_data, '0);
        chk("wt_idle", wt_data, '0);
      end
      if (tile_done) begin
        dones++;
        chk("done_after_last", 288'(step), 288'(T));
        chk("busy_done", 288'(busy), 288'(0));
      end
      if (s_ready) ready_seen++;
      feed_en = !(cyc >= gap_at && cyc < gap_at + gap_len);
      tick();
    end
    feed_en = 1'b1;
    steps = step;
  endtask

  initial begin
    int rc, st, dn, rs, bad;
    rstn = 1'b0;
    init_txn_pulse = 1'b0;
    s_valid = 1'b1;
    s_data = 32'hDEADBEEF;
    feed_en = 1'b1;

    // Reset with a live stream applied.
    repeat (3) tick();
    chk("rst_s_ready", 288'(s_ready), 288'(0));
    chk("rst_busy", 288'(busy), 288'(0));
    chk("rst_feed_valid", 288'(feed_valid), 288'(0));
    chk("rst_tile_done", 288'(tile_done), 288'(0));
    chk("rst_in_data", in_data, '0);
    chk("rst_wt_data", wt_data, '0);
    rstn = 1'b1;
    repeat (4) tick();
    chk("idle_s_ready", 288'(s_ready), 288'(0));
    chk("idle_busy", 288'(busy), 288'(0));
    chk("idle_feed_valid", 288'(feed_valid), 288'(0));
    s_valid = 1'b0;

    // Clean load and continuous feed.
    load_tile(0, -1, rc);
    feed_run(99, 0, st, dn, rs);
    $display("clean: ready=%0d steps=%0d dones=%0d", rc + rs, st, dn);
    chk("clean_ready_cycles", 288'(rc + rs), 288'(NW));
    chk("clean_steps", 288'(st), 288'(T));
    chk("clean_dones", 288'(dn), 288'(1));

    // Load with random idle gaps.
    load_tile(30, -1, rc);
    feed_run(99, 0, st, dn, rs);
    $display("gapped: steps=%0d dones=%0d", st, dn);
    chk("gap_steps", 288'(st), 288'(T));
    chk("gap_dones", 288'(dn), 288'(1));
    chk("gap_ready_in_feed", 288'(rs), 288'(0));

    // feed_en 1,0,0,1,... from the entry cycle.
    load_tile(0, -1, rc);
    feed_run(0, 2, st, dn, rs);
    $display("stall: steps=%0d dones=%0d", st, dn);
    chk("stall_steps", 288'(st), 288'(T));
    chk("stall_dones", 288'(dn), 288'(1));

    // Restart after 40 activation words.
    load_tile(0, 40, rc);
    feed_run(99, 0, st, dn, rs);
    $display("abort: steps=%0d dones=%0d", st, dn);
    chk("abort_steps", 288'(st), 288'(T));
    chk("abort_dones", 288'(dn), 288'(1));

    // Reset while step 5 is on the buses.
    load_tile(0, -1, rc);
    repeat (5) tick();
    chk("pre_rst_step5_in", in_data, exp_in(5));
    chk("pre_rst_step5_wt", wt_data, exp_wt(5));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("midrst_feed_valid", 288'(feed_valid), 288'(0));
    chk("midrst_busy", 288'(busy), 288'(0));
    chk("midrst_in", in_data, '0);
    chk("midrst_wt", wt_data, '0);
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      if (tile_done || feed_valid || busy) bad++;
      tick();
    end
    $display("midrst: stray activity cycles=%0d", bad);
    chk("midrst_no_done", 288'(bad), 288'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
